snake_head_controller: RTL and testbench

//  Generates the snake's head position and growth state, one grid step per move tick.

---
 rtl/snake_pkg.sv | 28 ++
 rtl/snake_step_timer.sv | 30 +++
 rtl/snake_head_controller.sv | 129 ++++++++++++
 tb/tb_snake_head_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game constants and direction codes, used by the head controller,
// the part shift register and the renderer.
package snake_pkg;

  localparam int COORD_W   = 11;
  localparam int CELL      = 20;
  localparam int H_MIN     = 0;
  localparam int H_MAX     = 620;
  localparam int V_MIN     = 0;
  localparam int V_MAX     = 460;
  localparam int START_H   = 320;
  localparam int START_V   = 240;
  localparam int START_LEN = 2;
  localparam int MAX_PARTS = 10;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Codes are paired so that flipping the LSB gives the reverse direction.
  function automatic dir_t opposite_dir(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Move-tick divider: counts 0..STEP_DIV-1, ticks on the last count, and is held
// at zero while hold is asserted.
module snake_step_timer #(
  parameter int STEP_DIV = 6_250_000
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  output logic tick
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (hold || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A held timer never ticks, so a halt on the last count swallows that step.
  assign tick = !hold && (cnt == LAST);

endmodule

// File: rtl/snake_head_controller.sv
// Snake head position, steering, wall collision and length tracking; advances one
// grid cell per move tick and pulses step_enable for the downstream shift register.
module snake_head_controller
  import snake_pkg::*;
#(
  parameter int STEP_DIV  = 6_250_000,
  parameter int CELL      = snake_pkg::CELL,
  parameter int H_MIN     = snake_pkg::H_MIN,
  parameter int H_MAX     = snake_pkg::H_MAX,
  parameter int V_MIN     = snake_pkg::V_MIN,
  parameter int V_MAX     = snake_pkg::V_MAX,
  parameter int START_H   = snake_pkg::START_H,
  parameter int START_V   = snake_pkg::START_V,
  parameter int START_LEN = snake_pkg::START_LEN,
  parameter int MAX_PARTS = snake_pkg::MAX_PARTS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 food_eaten,
  input  logic                 halt,
  output logic                 step_enable,
  output logic [COORD_W-1:0]   horizontal_head_coord,
  output logic [COORD_W-1:0]   vertical_head_coord,
  output logic [MAX_PARTS-1:0] isactive_parts,
  output logic                 you_lose_from_wall
);

  localparam int LEN_W = $clog2(MAX_PARTS + 1);
  localparam int SUM_W = COORD_W + 1;

  typedef logic signed [SUM_W-1:0] scoord_t;

  function automatic logic in_range(input scoord_t v, input int lo, input int hi);
    return (v >= scoord_t'(lo)) && (v <= scoord_t'(hi));
  endfunction

  function automatic logic [LEN_W-1:0] grow_sat(input logic [LEN_W-1:0] len);
    return (len >= LEN_W'(MAX_PARTS)) ? LEN_W'(MAX_PARTS) : len + 1'b1;
  endfunction

  dir_t             dir;
  dir_t             pending_dir;
  dir_t             btn_dir;
  logic             btn_any;
  logic             tick;
  logic             grow_pending;
  logic             grow_now;
  logic             move_ok;
  logic [LEN_W-1:0] length;
  scoord_t          x_next_s;
  scoord_t          y_next_s;

  snake_step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clock (clock),
    .reset (reset),
    .hold  (halt | you_lose_from_wall),
    .tick  (tick)
  );

  always_comb begin
    btn_any = btn_up | btn_down | btn_left | btn_right;
    btn_dir = DIR_RIGHT;
    if (btn_up)        btn_dir = DIR_UP;
    else if (btn_down) btn_dir = DIR_DOWN;
    else if (btn_left) btn_dir = DIR_LEFT;
  end

  // Candidate head one signed bit wider than the coordinate, so a step below zero
  // shows up as negative instead of wrapping.
  always_comb begin
    x_next_s = scoord_t'({1'b0, horizontal_head_coord});
    y_next_s = scoord_t'({1'b0, vertical_head_coord});
    case (pending_dir)
      DIR_UP:   y_next_s = y_next_s - scoord_t'(CELL);
      DIR_DOWN: y_next_s = y_next_s + scoord_t'(CELL);
      DIR_LEFT: x_next_s = x_next_s - scoord_t'(CELL);
      default:  x_next_s = x_next_s + scoord_t'(CELL);
    endcase
    move_ok  = in_range(x_next_s, H_MIN, H_MAX) && in_range(y_next_s, V_MIN, V_MAX);
    grow_now = grow_pending | food_eaten;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_enable           <= 1'b0;
      horizontal_head_coord <= COORD_W'(START_H);
      vertical_head_coord   <= COORD_W'(START_V);
      dir                   <= DIR_RIGHT;
      pending_dir           <= DIR_RIGHT;
      length                <= LEN_W'(START_LEN);
      grow_pending          <= 1'b0;
      you_lose_from_wall    <= 1'b0;
    end else begin
      step_enable  <= 1'b0;
      grow_pending <= grow_now;
      if (btn_any && btn_dir != opposite_dir(dir)) begin
        pending_dir <= btn_dir;
      end
      if (tick) begin
        if (move_ok) begin
          step_enable           <= 1'b1;
          horizontal_head_coord <= x_next_s[COORD_W-1:0];
          vertical_head_coord   <= y_next_s[COORD_W-1:0];
          dir                   <= pending_dir;
          grow_pending          <= 1'b0;
          if (grow_now) begin
            length <= grow_sat(length);
          end
        end else begin
          // Wall hit: head and length stay put; the flag also freezes the timer.
          you_lose_from_wall <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_PARTS; i++) begin
      isactive_parts[i] = (i < int'(length));
    end
  end

endmodule

// File: tb/tb_snake_head_controller.sv
// Bench for snake_head_controller with a fast move tick: directed vector table,
// corner-case sequences, then randomized play against a behavioural model.
module tb_snake_head_controller;

  localparam int STEP_DIV = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       food_eaten, halt;
  logic       step_enable;
  logic [10:0] hx, vy;
  logic [9:0] parts;
  logic       lose;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  snake_head_controller #(
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .btn_up                (btn_up),
    .btn_down              (btn_down),
    .btn_left              (btn_left),
    .btn_right             (btn_right),
    .food_eaten            (food_eaten),
    .halt                  (halt),
    .step_enable           (step_enable),
    .horizontal_head_coord (hx),
    .vertical_head_coord   (vy),
    .isactive_parts        (parts),
    .you_lose_from_wall    (lose)
  );

  // Behavioural model: pixel position, direction index, length, move phase.
  int mx, my, mdir, mpend, mlen, mcnt;
  bit mlose, mgrow, mstep;
  int dxs[4] = '{0, 0, -20, 20};
  int dys[4] = '{-20, 20, 0, 0};
  int opp[4] = '{1, 0, 3, 2};

  typedef struct {
    logic [3:0] btn;   // {up, down, left, right}
    logic       food;
    int         ex;
    int         ey;
    int         eparts;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] b, input logic f, input logic h);
    btn_up = b[3]; btn_down = b[2]; btn_left = b[1]; btn_right = b[0];
    food_eaten = f;
    halt = h;
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset;
    mx = 320; my = 240; mdir = 3; mpend = 3; mlen = 2; mcnt = 0;
    mlose = 0; mgrow = 0; mstep = 0;
  endtask

  task automatic do_reset;
    drive(4'b0000, 1'b0, 1'b0);
    reset = 1'b1;
    cyc;
    cyc;
    reset = 1'b0;
    model_reset;
  endtask

  // One clock edge of the game rules, using the inputs present before the edge.
  task automatic model_edge(input logic [3:0] b, input logic f, input logic h);
    int  nx, ny, old_dir, cand;
    bit  old_lose, tick;
    old_dir  = mdir;
    old_lose = mlose;
    tick     = (mcnt == STEP_DIV - 1) && !h && !mlose;
    mstep    = 0;
    if (tick) begin
      nx = mx + dxs[mpend];
      ny = my + dys[mpend];
      if (nx >= 0 && nx <= 620 && ny >= 0 && ny <= 460) begin
        mx = nx; my = ny; mdir = mpend; mstep = 1;
        if (mgrow || f) mlen = (mlen < 10) ? mlen + 1 : 10;
        mgrow = 0;
      end else begin
        mlose = 1;
        mgrow = mgrow || f;
      end
    end else begin
      mgrow = mgrow || f;
    end
    mcnt = (h || old_lose) ? 0 : (mcnt + 1) % STEP_DIV;
    cand = -1;
    for (int k = 0; k < 4; k++) begin
      if (cand < 0 && b[3-k]) cand = k;
    end
    if (cand >= 0 && cand != opp[old_dir]) mpend = cand;
  endtask

  // Runs one move interval; inputs are pulsed during its first cycle only.
  task automatic run_interval(input logic [3:0] b, input logic f);
    drive(b, f, 1'b0);
    for (int k = 0; k < STEP_DIV; k++) begin
      cyc;
      if (k == 0) drive(4'b0000, 1'b0, 1'b0);
      if (k < STEP_DIV - 1) check("step_gap", int'(step_enable), 0);
    end
  endtask

  initial begin
    logic [3:0] rb;
    logic       rf, rh;

    tbl[0]  = '{4'b0000, 1'b0, 340, 240, 'h3};
    tbl[1]  = '{4'b0000, 1'b0, 360, 240, 'h3};
    tbl[2]  = '{4'b0010, 1'b0, 380, 240, 'h3};
    tbl[3]  = '{4'b1000, 1'b0, 380, 220, 'h3};
    tbl[4]  = '{4'b0000, 1'b1, 380, 200, 'h7};
    tbl[5]  = '{4'b0000, 1'b0, 380, 180, 'h7};
    tbl[6]  = '{4'b0100, 1'b0, 380, 160, 'h7};
    tbl[7]  = '{4'b0001, 1'b0, 400, 160, 'h7};
    tbl[8]  = '{4'b0100, 1'b0, 400, 180, 'h7};
    tbl[9]  = '{4'b0010, 1'b0, 380, 180, 'h7};
    tbl[10] = '{4'b0000, 1'b1, 360, 180, 'hF};
    tbl[11] = '{4'b1000, 1'b0, 360, 160, 'hF};

    drive(4'b0000, 1'b0, 1'b0);
    reset = 1'b1;
    #12;
    check("reset_step", int'(step_enable), 0);
    check("reset_x", int'(hx), 320);
    check("reset_y", int'(vy), 240);
    check("reset_parts", int'(parts), 'h3);
    check("reset_lose", int'(lose), 0);
    do_reset;

    for (int i = 0; i < 12; i++) begin
      run_interval(tbl[i].btn, tbl[i].food);
      check($sformatf("vec%0d_step", i), int'(step_enable), 1);
      check($sformatf("vec%0d_x", i), int'(hx), tbl[i].ex);
      check($sformatf("vec%0d_y", i), int'(vy), tbl[i].ey);
      check($sformatf("vec%0d_parts", i), int'(parts), tbl[i].eparts);
      check($sformatf("vec%0d_lose", i), int'(lose), 0);
    end

    // Right wall: reach 620, then the next tick with food is a wall hit.
    do_reset;
    for (int i = 1; i <= 15; i++) run_interval(4'b0000, 1'b0);
    check("wall_reach_x", int'(hx), 620);
    run_interval(4'b0000, 1'b1);
    check("wall_step", int'(step_enable), 0);
    check("wall_lose", int'(lose), 1);
    check("wall_x", int'(hx), 620);
    check("wall_parts", int'(parts), 'h3);
    run_interval(4'b0000, 1'b0);
    check("wall_hold_step", int'(step_enable), 0);
    check("wall_hold_lose", int'(lose), 1);
    check("wall_hold_x", int'(hx), 620);

    // Length saturation over 11 food pulses.
    do_reset;
    check("after_wall_reset_lose", int'(lose), 0);
    for (int k = 1; k <= 11; k++) begin
      run_interval(4'b0000, 1'b1);
      check($sformatf("sat%0d_parts", k), int'(parts), (1 << ((2 + k > 10) ? 10 : 2 + k)) - 1);
      check($sformatf("sat%0d_x", k), int'(hx), 320 + 20 * k);
    end

    // Halt freezes the timer; the first step comes a full interval after release.
    do_reset;
    cyc;
    halt = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc;
      check("halt_step", int'(step_enable), 0);
    end
    halt = 1'b0;
    for (int k = 0; k < STEP_DIV; k++) begin
      cyc;
      check($sformatf("release%0d_step", k), int'(step_enable), (k == STEP_DIV - 1) ? 1 : 0);
    end
    check("release_x", int'(hx), 340);

    // Asynchronous reset mid-game.
    do_reset;
    run_interval(4'b0000, 1'b1);
    run_interval(4'b0000, 1'b1);
    run_interval(4'b0000, 1'b1);
    run_interval(4'b0000, 1'b0);
    check("mid_x", int'(hx), 400);
    check("mid_parts", int'(parts), 'h1F);
    cyc;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_x", int'(hx), 320);
    check("async_rst_y", int'(vy), 240);
    check("async_rst_parts", int'(parts), 'h3);
    check("async_rst_lose", int'(lose), 0);
    check("async_rst_step", int'(step_enable), 0);
    cyc;
    reset = 1'b0;
    model_reset;

    // Randomized play against the model.
    do_reset;
    for (int i = 0; i < 4000; i++) begin
      if (mlose && $urandom_range(0, 15) == 0) do_reset;
      rb = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      rf = ($urandom_range(0, 19) == 0);
      rh = ($urandom_range(0, 11) == 0);
      drive(rb, rf, rh);
      cyc;
      model_edge(rb, rf, rh);
      check("rnd_step", int'(step_enable), int'(mstep));
      check("rnd_x", int'(hx), mx);
      check("rnd_y", int'(vy), my);
      check("rnd_parts", int'(parts), (1 << mlen) - 1);
      check("rnd_lose", int'(lose), int'(mlose));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
